// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection filter chain.
//   rgb30_t : packed pixel {R[29:20], G[19:10], B[9:0]}, 10 bits per channel
//   chan_t  : 8-bit channel / luma level
//   luma8() : 8-bit luma approximation (R + 2G + B) / 4 on the top 8 bits of each channel
package edge_pkg;

    typedef logic [29:0] rgb30_t;
    typedef logic [7:0]  chan_t;

    localparam int unsigned IMG_WIDTH  = 320;
    localparam int unsigned IMG_HEIGHT = 240;

    // Worst case 255 + 510 + 255 = 1020, so a 10-bit sum never overflows.
    function automatic chan_t luma8(input rgb30_t px);
        logic [9:0] sum;
        sum = {2'b00, px[29:22]} + {1'b0, px[19:12], 1'b0} + {2'b00, px[9:2]};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/edge_threshold_if.sv
// Pixel stream (dstream) handshake between filter stages.
//   valid : source has a pixel on data
//   ready : sink accepts the pixel this cycle
//   data  : packed RGB pixel (edge_pkg::rgb30_t)
// Modports: master drives valid/data, slave drives ready.
interface edge_threshold_if;

    logic               valid;
    logic               ready;
    edge_pkg::rgb30_t   data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/edge_pixel_counter.sv
// Raster position tracker for a WIDTH x HEIGHT frame.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   advance    : one pixel accepted this cycle
//   col, row   : position of the next pixel to be accepted
//   first_px   : next pixel is (0,0)
//   last_px    : next pixel is (WIDTH-1, HEIGHT-1)
module edge_pixel_counter #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 240,
    localparam int unsigned CW    = $clog2(WIDTH),
    localparam int unsigned RW    = $clog2(HEIGHT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          first_px,
    output logic          last_px
);

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else if (advance) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign col      = col_q;
    assign row      = row_q;
    assign first_px = (col_q == '0) && (row_q == '0);
    assign last_px  = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/edge_threshold.sv
// Edge-map binariser behind the 5x5 edge convolution stage.
// Each pixel's luma is compared with a threshold latched at the first pixel of every frame;
// a BORDER-pixel frame rim (invalid convolution taps) is always background.
// Two-stage pipeline (accept -> luma/border -> output), stalls as a whole on y backpressure.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   x           : input pixel stream (slave)
//   y           : edge-map stream (master), EDGE_RGB on all channels for an edge, else 0
//   threshold   : luma threshold, sampled with pixel (0,0)
//   edge_count  : edge pixels in last complete frame
//   frame_done  : one-cycle pulse after the last pixel of a frame leaves y
// Build option: EDGE_THRESHOLD_COUNT_EN enables edge_count/frame_done; otherwise both are tied 0.
module edge_threshold
    import edge_pkg::*;
#(
    parameter int unsigned WIDTH    = IMG_WIDTH,
    parameter int unsigned HEIGHT   = IMG_HEIGHT,
    parameter int unsigned BORDER   = 2,
    parameter logic [7:0]  EDGE_RGB = 8'hFF
) (
    input  logic                      clk,
    input  logic                      reset,
    edge_threshold_if.slave           x,
    edge_threshold_if.master          y,
    input  chan_t                     threshold,
    output logic [16:0]               edge_count,
    output logic                      frame_done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LO = CW'(BORDER);
    localparam logic [CW-1:0] COL_HI = CW'(WIDTH - BORDER);
    localparam logic [RW-1:0] ROW_LO = RW'(BORDER);
    localparam logic [RW-1:0] ROW_HI = RW'(HEIGHT - BORDER);

    localparam rgb30_t EDGE_WORD = {EDGE_RGB, 2'b00, EDGE_RGB, 2'b00, EDGE_RGB, 2'b00};

    logic          en;
    logic          accept;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          first_px;
    logic          last_px;
    logic          border;
    chan_t         thr_q;
    chan_t         thr_px;

    logic          s1_valid_q;
    chan_t         s1_luma_q;
    logic          s1_border_q;
    chan_t         s1_thr_q;
    logic          hit_d;

    logic          y_valid_q;
    rgb30_t        y_data_q;

    // The whole pipe moves together: a bubble in y or a taker on y frees every stage.
    assign en      = y.ready | ~y_valid_q;
    assign x.ready = en;
    assign accept  = x.valid & en;

    edge_pixel_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk      (clk),
        .reset    (reset),
        .advance  (accept),
        .col      (col),
        .row      (row),
        .first_px (first_px),
        .last_px  (last_px)
    );

    assign border = (col < COL_LO) | (col >= COL_HI) | (row < ROW_LO) | (row >= ROW_HI);

    // Pixel (0,0) must already see the new threshold, so bypass thr_q for it.
    assign thr_px = first_px ? threshold : thr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q <= 8'h80;
        end else if (accept && first_px) begin
            thr_q <= threshold;
        end
    end

    // The threshold travels with the pixel so a frame boundary inside the pipe stays exact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_luma_q   <= '0;
            s1_border_q <= 1'b0;
            s1_thr_q    <= '0;
        end else if (en) begin
            s1_valid_q  <= x.valid;
            s1_luma_q   <= luma8(x.data);
            s1_border_q <= border;
            s1_thr_q    <= thr_px;
        end
    end

    assign hit_d = s1_valid_q & ~s1_border_q & (s1_luma_q >= s1_thr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else if (en) begin
            y_valid_q <= s1_valid_q;
            y_data_q  <= hit_d ? EDGE_WORD : '0;
        end
    end

    assign y.valid = y_valid_q;
    assign y.data  = y_data_q;

`ifdef EDGE_THRESHOLD_COUNT_EN
    logic        s1_last_q;
    logic        s2_last_q;
    logic        s2_hit_q;
    logic        handoff;
    logic [16:0] running_q;
    logic [16:0] edge_count_q;
    logic        frame_done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_last_q <= 1'b0;
            s2_last_q <= 1'b0;
            s2_hit_q  <= 1'b0;
        end else if (en) begin
            s1_last_q <= x.valid & last_px;
            s2_last_q <= s1_valid_q & s1_last_q;
            s2_hit_q  <= hit_d;
        end
    end

    assign handoff = y_valid_q & y.ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running_q    <= '0;
            edge_count_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (handoff) begin
                if (s2_last_q) begin
                    edge_count_q <= running_q + 17'(s2_hit_q);
                    running_q    <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    running_q <= running_q + 17'(s2_hit_q);
                end
            end
        end
    end

    assign edge_count = edge_count_q;
    assign frame_done = frame_done_q;
`else
    logic unused_last_px;
    assign unused_last_px = last_px;
    assign edge_count     = '0;
    assign frame_done     = 1'b0;
`endif

endmodule

// File: tb/tb_edge_threshold.sv
// Scoreboard bench for edge_threshold on a reduced 40x30 frame.
module tb_edge_threshold;

    localparam int W         = 40;
    localparam int H         = 30;
    localparam int B         = 2;
    localparam int NPIX      = W * H;
    localparam int INTERIOR  = (W - 2 * B) * (H - 2 * B);
    localparam logic [29:0] EDGE_WORD = 30'h3FCFF3FC;

    typedef struct {
        logic [29:0] data;
        bit          last;
        int          frame_edges;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  threshold = 8'h00;
    logic [16:0] edge_count;
    logic        frame_done;

    edge_threshold_if x_if ();
    edge_threshold_if y_if ();

    edge_threshold #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .BORDER   (B),
        .EDGE_RGB (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x_if),
        .y          (y_if),
        .threshold  (threshold),
        .edge_count (edge_count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          m_idx = 0;
    logic [7:0]  m_thr = 8'h80;
    int          m_edges = 0;
    int          bp_pct = 0;
    int          gap_pct = 0;
    int          last_frame_edges = -1;

    bit          pend_fd = 1'b0;
    int          fd_exp = 0;
    bit          prev_stall = 1'b0;
    logic [29:0] prev_data = '0;
    int          out_edges = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_luma(input logic [29:0] px);
        int r = int'(px[29:20]) / 4;
        int g = int'(px[19:10]) / 4;
        int b = int'(px[9:0]) / 4;
        return (r + 2 * g + b) / 4;
    endfunction

    // Reference: position from the pixel index, threshold frozen at index 0.
    task automatic model_accept(input logic [29:0] px);
        int   col = m_idx % W;
        int   row = m_idx / W;
        bit   in_border;
        bit   is_edge;
        exp_t e;
        if (m_idx == 0) begin
            m_thr   = threshold;
            m_edges = 0;
        end
        in_border = col < B || col >= W - B || row < B || row >= H - B;
        is_edge   = !in_border && ref_luma(px) >= int'(m_thr);
        m_edges  += int'(is_edge);
        e.data        = is_edge ? EDGE_WORD : 30'd0;
        e.last        = (m_idx == NPIX - 1);
        e.frame_edges = m_edges;
        sb.push_back(e);
        m_idx = (m_idx + 1) % NPIX;
    endtask

    function automatic logic [29:0] gen_px(input int mode, input int idx);
        logic [9:0] c;
        int         base;
        int         v;
        case (mode)
            1: return {10'h3FF, 10'h3FF, 10'h3FF};
            2: begin
                base = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'hF0;
                v    = base + int'($urandom_range(0, 4)) - 2;
                c    = {v[7:0], 2'($urandom_range(0, 3))};
                return {c, c, c};
            end
            3: begin
                c = (idx % 2 == 0) ? 10'h104 : 10'h0FC;
                return {c, c, c};
            end
            default: return 30'($urandom);
        endcase
    endfunction

    task automatic send_pixel(input logic [29:0] px);
        int waited = 0;
        @(negedge clk);
        while ($urandom_range(0, 99) < gap_pct) begin
            x_if.valid = 1'b0;
            @(negedge clk);
        end
        x_if.valid = 1'b1;
        x_if.data  = px;
        forever begin
            #1;
            if (x_if.ready) break;
            waited++;
            if (waited > 500) begin
                errors++;
                $display("FAIL x_ready_timeout: got 0, expected 1 at %0t", $time);
                $fatal(1, "x.ready stuck low");
            end
            @(negedge clk);
        end
        model_accept(px);
    endtask

    task automatic send_frame(input int mode, input int npix, input int chg_idx,
                              input logic [7:0] new_thr);
        for (int k = 0; k < npix; k++) begin
            if (k == chg_idx) threshold = new_thr;
            send_pixel(gen_px(mode, m_idx));
        end
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        x_if.valid = 1'b0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Reset asserted between edges; optionally with a pixel offered in the same cycle.
    task automatic reset_pulse(input bit offer, input logic [29:0] px);
        @(negedge clk);
        if (offer) begin
            x_if.valid = 1'b1;
            x_if.data  = px;
        end
        #3 reset = 1'b1;
        #1;
        check("rst_y_valid", 32'(y_if.valid), 32'd0);
        check("rst_y_data", 32'(y_if.data), 32'd0);
        check("rst_edge_count", 32'(edge_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        sb.delete();
        m_idx = 0;
        @(negedge clk);
        #3;
        x_if.valid = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            y_if.ready = ($urandom_range(0, 99) >= bp_pct);
        end
    end

    // Monitor: pops one expectation per y transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                pend_fd    = 1'b0;
                prev_stall = 1'b0;
                out_edges  = 0;
                continue;
            end
`ifdef EDGE_THRESHOLD_COUNT_EN
            check("frame_done", 32'(frame_done), 32'(pend_fd));
            if (pend_fd) check("edge_count", 32'(edge_count), 32'(fd_exp));
`else
            check("count_tied_off", {14'd0, frame_done, edge_count}, 32'd0);
`endif
            pend_fd = 1'b0;
            if (prev_stall) begin
                check("stall_valid", 32'(y_if.valid), 32'd1);
                check("stall_data", 32'(y_if.data), 32'(prev_data));
            end
            if (y_if.valid && y_if.ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected no pixel", y_if.data);
                end else begin
                    e = sb.pop_front();
                    check("pixel", 32'(y_if.data), 32'(e.data));
                    out_edges += int'(y_if.data == EDGE_WORD);
                    if (e.last) begin
                        pend_fd          = 1'b1;
                        fd_exp           = e.frame_edges;
                        last_frame_edges = out_edges;
                        out_edges        = 0;
                    end
                end
            end
            prev_stall = y_if.valid && !y_if.ready;
            prev_data  = y_if.data;
        end
    end

    initial begin
        x_if.valid = 1'b0;
        x_if.data  = '0;
        y_if.ready = 1'b1;
        #2;
        check("init_y_valid", 32'(y_if.valid), 32'd0);
        check("init_y_data", 32'(y_if.data), 32'd0);
        check("init_edge_count", 32'(edge_count), 32'd0);
        check("init_frame_done", 32'(frame_done), 32'd0);
        check("init_x_ready", 32'(x_if.ready), 32'd1);
        @(negedge clk);
        #3 reset = 1'b0;

        // 0x104 -> luma 0x41 (edge), 0x0FC -> luma 0x3F (background) at threshold 0x40
        threshold = 8'h40;
        send_frame(3, NPIX, -1, 8'h00);
        drain();

        // Saturated frame, threshold 0: only the rim is background
        threshold = 8'h00;
        send_frame(1, NPIX, -1, 8'h00);
        drain();
        check("interior_edges", 32'(last_frame_edges), 32'(INTERIOR));
`ifdef EDGE_THRESHOLD_COUNT_EN
        check("edge_count_full", 32'(edge_count), 32'(INTERIOR));
`endif

        // Random pixels and threshold under backpressure and input gaps
        bp_pct    = 50;
        gap_pct   = 20;
        threshold = 8'($urandom_range(0, 255));
        send_frame(0, NPIX, -1, 8'h00);

        // Threshold moved mid-frame: rest of frame keeps 0x10, next frame uses 0xF0
        threshold = 8'h10;
        send_frame(2, NPIX, 10 * W + 5, 8'hF0);
        send_frame(2, NPIX, -1, 8'h00);
        drain();

        // Reset mid-frame, then reset colliding with the last pixel of a frame
        threshold = 8'h20;
        bp_pct    = 30;
        send_frame(0, 500, -1, 8'h00);
        reset_pulse(1'b0, 30'd0);
        send_frame(0, NPIX - 1, -1, 8'h00);
        reset_pulse(1'b1, 30'h3FFFFFFF);
        send_frame(0, NPIX, -1, 8'h00);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
